// File: rtl/issuer_pkg.sv
// Shared types for the dependency-aware command issuer: command record,
// scoreboard entry and controller state encoding.
package issuer_pkg;

  localparam int CMD_ID_W   = 8;
  localparam int CMD_DATA_W = 64;

  typedef struct packed {
    logic [CMD_ID_W-1:0]   id;
    logic [CMD_ID_W-1:0]   dep;
    logic                  has_dep;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic                valid;
    logic [CMD_ID_W-1:0] id;
  } sb_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIN_ACK,
    S_CMD_GET,
    S_CMD_CHECK,
    S_CMD_WB,
    S_SELECT,
    S_LOAD
  } state_t;

endpackage

// File: rtl/dep_issuer_proc_pick.sv
// proc_pick: combinational eligible-mask to processor-index selection.
// RR=0 picks the lowest set bit; RR=1 picks the first set bit at or after
// i_ptr, wrapping N-1 -> 0.
module proc_pick #(
  parameter int N  = 4,
  parameter bit RR = 1'b0,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // scan N candidates starting at the policy's start index, keep the first hit
  always_comb begin
    int w_start;
    int w_j;
    o_idx   = '0;
    o_any   = 1'b0;
    w_start = RR ? int'(i_ptr) : 0;
    w_j     = 0;
    for (int i = 0; i < N; i++) begin
      w_j = (w_start + i) % N;
      if (!o_any && i_mask[w_j]) begin
        o_any = 1'b1;
        o_idx = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/dep_issuer.sv
// dep_issuer: pops commands from a FWFT FIFO, requeues those whose dependency
// is still in flight on some processor, otherwise loads them beat by beat into
// an idle processor and tracks it in a per-processor scoreboard.
// Optional build macro DEP_ISSUER_RR_EN: round-robin processor pick instead of
// lowest-index pick. ID_W/CMD_W must match the widths of cmd_t in issuer_pkg.
module dep_issuer import issuer_pkg::*; #(
  parameter int PROC_COUNT = 4,
  parameter int ID_W       = CMD_ID_W,
  parameter int CMD_W      = CMD_DATA_W,
  parameter int BEATS      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  input  cmd_t                    i_cmd,
  output logic                    o_read,
  output logic                    o_write,
  output cmd_t                    o_cmd,
  input  logic [PROC_COUNT-1:0]   i_busy,
  input  logic [PROC_COUNT-1:0]   i_finish,
  input  logic                    i_ack,
  output logic [PROC_COUNT-1:0]   o_en,
  output logic [$clog2(BEATS):0]  o_beat,
  output cmd_t                    o_instr,
  output logic [PROC_COUNT-1:0]   o_finish_ack,
  output logic                    o_idle
);

  localparam int PW = $clog2(PROC_COUNT);
  localparam int BW = $clog2(BEATS) + 1;
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PROC_COUNT-1:0] ONE_HOT0  = PROC_COUNT'(1);

  state_t                        r_state, w_next;
  sb_entry_t [PROC_COUNT-1:0]    r_sb;
  cmd_t                          r_cmd;
  logic [PW-1:0]                 r_sel, r_fin;
  logic [BW-1:0]                 r_beat;

  logic [PROC_COUNT-1:0] w_valid, w_elig;
  logic [PW-1:0]         w_fin_idx, w_pick, w_ptr;
  logic                  w_dep_hit, w_any, w_last;

  // scoreboard views: valid mask, dependency match, lowest pending finish
  always_comb begin
    w_valid   = '0;
    w_dep_hit = 1'b0;
    w_fin_idx = '0;
    for (int k = PROC_COUNT - 1; k >= 0; k--) begin
      w_valid[k] = r_sb[k].valid;
      if (r_sb[k].valid && r_cmd.has_dep &&
          r_cmd.dep[ID_W-1:0] == r_sb[k].id[ID_W-1:0])
        w_dep_hit = 1'b1;
      if (i_finish[k]) w_fin_idx = PW'(k);
    end
  end

  assign w_elig = ~i_busy & ~w_valid;
  assign w_last = i_ack && (r_beat == LAST_BEAT);

`ifdef DEP_ISSUER_RR_EN
  localparam bit RR = 1'b1;
  // r_ptr holds the first candidate after the last completed load
  // (last_sel+1 mod PROC_COUNT), so its cleared value starts at processor 0.
  logic [PW-1:0] r_ptr;

  // advance the round-robin start only when a load completes
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ptr <= '0;
    else if (r_state == S_LOAD && w_last)
      r_ptr <= (r_sel == PW'(PROC_COUNT - 1)) ? '0 : r_sel + 1'b1;
  end
  assign w_ptr = r_ptr;
`else
  localparam bit RR = 1'b0;
  assign w_ptr = '0;
`endif

  proc_pick #(.N(PROC_COUNT), .RR(RR), .PW(PW)) u_pick (
    .i_mask (w_elig),
    .i_ptr  (w_ptr),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state: finishes win over dispatch, and are only looked at in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|i_finish)                w_next = S_FIN_ACK;
        else if (i_cmd_valid && w_any) w_next = S_CMD_GET;
      end
      S_FIN_ACK:   w_next = S_IDLE;
      S_CMD_GET:   w_next = S_CMD_CHECK;
      S_CMD_CHECK: w_next = w_dep_hit ? S_CMD_WB : S_SELECT;
      S_CMD_WB:    w_next = S_IDLE;
      S_SELECT:    if (w_any) w_next = S_LOAD;
      S_LOAD:      if (w_last) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // datapath: finish latch, command capture, selection, beat count, scoreboard
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sb   <= '0;
      r_cmd  <= '0;
      r_sel  <= '0;
      r_fin  <= '0;
      r_beat <= '0;
    end else begin
      case (r_state)
        S_IDLE:    if (|i_finish) r_fin <= w_fin_idx;
        S_FIN_ACK: r_sb[r_fin] <= '0;
        S_CMD_GET: r_cmd <= i_cmd;
        S_SELECT: begin
          if (w_any) begin
            r_sel  <= w_pick;
            r_beat <= '0;
          end
        end
        S_LOAD: begin
          if (i_ack) begin
            if (r_beat == LAST_BEAT) r_sb[r_sel] <= '{valid: 1'b1, id: r_cmd.id};
            else                     r_beat      <= r_beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from state; forced quiet while reset is asserted
  always_comb begin
    o_read       = 1'b0;
    o_write      = 1'b0;
    o_cmd        = '0;
    o_en         = '0;
    o_beat       = '0;
    o_instr      = '0;
    o_finish_ack = '0;
    o_idle       = 1'b0;
    if (i_rst) begin
      o_idle = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:    o_idle       = ~|w_valid;
        S_FIN_ACK: o_finish_ack = ONE_HOT0 << r_fin;
        S_CMD_GET: o_read       = 1'b1;
        S_CMD_WB: begin
          o_write = 1'b1;
          o_cmd   = r_cmd;
        end
        S_LOAD: begin
          o_en         = ONE_HOT0 << r_sel;
          o_beat       = r_beat;
          o_instr      = r_cmd;
          o_instr.data = CMD_DATA_W'(r_cmd.data[CMD_W-1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule
